// File: rtl/core_pkg.sv
// Core-wide rename constants shared by the free list, rename, rob and busy table.
// Also provides idx_w(), an index-width helper that never returns zero.
package core_pkg;

  localparam int WIDTH_PRD = 7;
  localparam int NUM_ARCH  = 32;
  localparam int WIDTH_BRM = 3;
  localparam int WIDTH_PTR = WIDTH_PRD + 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freelist_mp_if.sv
// Rename-side bundle of the multi-port free list: alloc, release, checkpoint, status.
// master = rename/commit driver, slave = freelist_mp.
interface freelist_mp_if
  import core_pkg::*;
#(
    parameter int WIDTH_PRD = core_pkg::WIDTH_PRD,
    parameter int NUM_ALLOC = 4,
    parameter int NUM_FREE  = 4,
    parameter int NUM_CKPT  = core_pkg::WIDTH_BRM
) ();

    localparam int ALLOC_W = $clog2(NUM_ALLOC + 1);
    localparam int CKPT_W  = idx_w(NUM_CKPT);

    logic [NUM_ALLOC*WIDTH_PRD-1:0] o_data;
    logic                           o_ready;
    logic [WIDTH_PRD:0]             o_count;
    logic                           o_ovf;
    logic [ALLOC_W-1:0]             i_alloc_cnt;
    logic [NUM_FREE-1:0]            i_free_en;
    logic [NUM_FREE*WIDTH_PRD-1:0]  i_free_prd;
    logic                           i_snap_en;
    logic [CKPT_W-1:0]              i_snap_id;
    logic                           i_kill_en;
    logic [CKPT_W-1:0]              i_kill_id;

    modport master (
        input  o_data, o_ready, o_count, o_ovf,
        output i_alloc_cnt, i_free_en, i_free_prd,
        output i_snap_en, i_snap_id, i_kill_en, i_kill_id
    );

    modport slave (
        output o_data, o_ready, o_count, o_ovf,
        input  i_alloc_cnt, i_free_en, i_free_prd,
        input  i_snap_en, i_snap_id, i_kill_en, i_kill_id
    );

endinterface

// File: rtl/freelist_mp_free_compact.sv
// Prefix-popcount lane compactor: maps enabled, non-zero release lanes to dense
// write offsets and reports how many lanes are written.
module free_compact #(
    parameter int NUM_FREE  = 4,
    parameter int WIDTH_PRD = 7,
    parameter int CNT_W     = $clog2(NUM_FREE + 1)
) (
    input  logic [NUM_FREE-1:0]            en,
    input  logic [NUM_FREE*WIDTH_PRD-1:0]  prd,
    output logic [NUM_FREE-1:0]            vld,
    output logic [NUM_FREE-1:0][CNT_W-1:0] off,
    output logic [CNT_W-1:0]               total
);

    always_comb begin
        logic [CNT_W-1:0] acc;
        // NOTE: blocking assignments make acc a running sum within one evaluation,
        // which is what a prefix count needs; every output gets a default first so
        // no latch is inferred.
        acc   = '0;
        vld   = '0;
        off   = '0;
        for (int k = 0; k < NUM_FREE; k++) begin
            // Tag 0 is the permanent x0 mapping and is never returned.
            vld[k] = en[k] && (prd[k*WIDTH_PRD +: WIDTH_PRD] != '0);
            off[k] = acc;
            acc    = acc + CNT_W'(vld[k]);
        end
        total = acc;
    end

endmodule

// File: rtl/freelist_mp.sv
// Multi-port circular free list of physical register tags for the rename stage.
// Branch checkpoints (snap/kill) are built only when FREELIST_CHECKPOINT_EN is defined.
module freelist_mp
  import core_pkg::*;
#(
    parameter int WIDTH_PRD = core_pkg::WIDTH_PRD,
    parameter int NUM_ARCH  = core_pkg::NUM_ARCH,
    parameter int NUM_ALLOC = 4,
    parameter int NUM_FREE  = 4,
    parameter int NUM_CKPT  = core_pkg::WIDTH_BRM
) (
    input logic           i_clk,
    input logic           i_rst,
    freelist_mp_if.slave  bus
);

    localparam int DEPTH = 2 ** WIDTH_PRD;
    localparam int PTR_W = WIDTH_PRD + 1;
    localparam int CAP   = DEPTH - NUM_ARCH;
    localparam int CNT_W = $clog2(NUM_FREE + 1);

    typedef logic [PTR_W-1:0]     ptr_t;
    typedef logic [WIDTH_PRD-1:0] prd_t;

    prd_t mem [DEPTH];
    ptr_t head, tail, count;
    ptr_t head_alloc, head_next, tail_free;
    logic ovf, alloc_ok, alloc_udf, free_ok;

    logic [NUM_FREE-1:0]            free_vld;
    logic [NUM_FREE-1:0][CNT_W-1:0] free_off;
    logic [CNT_W-1:0]               free_total;

    free_compact #(
        .NUM_FREE  (NUM_FREE),
        .WIDTH_PRD (WIDTH_PRD),
        .CNT_W     (CNT_W)
    ) u_compact (
        .en    (bus.i_free_en),
        .prd   (bus.i_free_prd),
        .vld   (free_vld),
        .off   (free_off),
        .total (free_total)
    );

`ifdef FREELIST_CHECKPOINT_EN
    ptr_t slot [NUM_CKPT];
    logic kill_act, snap_act;

    assign kill_act = bus.i_kill_en && (int'(bus.i_kill_id) < NUM_CKPT);
    assign snap_act = bus.i_snap_en && (int'(bus.i_snap_id) < NUM_CKPT) && !kill_act;
`else
    logic unused_ckpt;
    assign unused_ckpt = ^{bus.i_snap_en, bus.i_snap_id, bus.i_kill_en, bus.i_kill_id};
`endif

    assign count = tail - head;

    always_comb begin
        alloc_ok   = PTR_W'(bus.i_alloc_cnt) <= count;
        head_alloc = alloc_ok ? head + PTR_W'(bus.i_alloc_cnt) : head;
        head_next  = head_alloc;
        alloc_udf  = !alloc_ok;
`ifdef FREELIST_CHECKPOINT_EN
        // A kill discards this cycle's allocation, so it cannot underflow either.
        if (kill_act) begin
            head_next = slot[bus.i_kill_id];
            alloc_udf = 1'b0;
        end
`endif
        tail_free = tail + PTR_W'(free_total);
        free_ok   = (tail_free - head_next) <= PTR_W'(CAP);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head <= '0;
            tail <= PTR_W'(CAP);
            ovf  <= 1'b0;
            // NOTE: the tag storage is reset on purpose: the initial free tags must
            // be present from the first cycle, so it cannot be left as plain RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i < CAP) ? prd_t'(i + NUM_ARCH) : '0;
            end
        end else begin
            head <= head_next;
            if (free_ok) begin
                tail <= tail_free;
                for (int k = 0; k < NUM_FREE; k++) begin
                    if (free_vld[k]) begin
                        mem[tail[WIDTH_PRD-1:0] + prd_t'(free_off[k])] <=
                            bus.i_free_prd[k*WIDTH_PRD +: WIDTH_PRD];
                    end
                end
            end
            if (alloc_udf || !free_ok) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef FREELIST_CHECKPOINT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < NUM_CKPT; s++) begin
                slot[s] <= '0;
            end
        end else if (snap_act) begin
            // The branch bundle's own allocations stay live across a rollback.
            slot[bus.i_snap_id] <= head_alloc;
        end
    end
`endif

    always_comb begin
        bus.o_data = '0;
        for (int k = 0; k < NUM_ALLOC; k++) begin
            bus.o_data[k*WIDTH_PRD +: WIDTH_PRD] = mem[head[WIDTH_PRD-1:0] + prd_t'(k)];
        end
    end

    assign bus.o_count = count;
    assign bus.o_ready = count >= PTR_W'(NUM_ALLOC);
    assign bus.o_ovf   = ovf;

endmodule
